stage_seq: RTL and testbench
============================

Name: stage_seq

Overview:
- Core-side sequencer for the RIVER multicycle core; it produces `cycle_end` for the clock management unit.
- Steps the core through FE, DE, EX, MEM and WB, advancing at most one stage per cycle in which `clk_enable` is high.
- Drives one-hot stage strobes to the datapath and counts retired instructions.
- Handles memory wait states, wait timeouts and traps, ending the instruction in a defined way in each case.

Parameters:
- RET_W, 32, width of the retired-instruction counter
- WAIT_TIMEOUT, 255, max consecutive enabled cycles a wait may be held before abort; 0 disables the timeout
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > WAIT_TIMEOUT

Ports:
- clk_in  in  1  core clock; the same clock the clock management unit uses
- rst  in  1  synchronous reset, active-high
- clk_enable  in  1  advance qualifier from the clock management unit
- fe_wait  in  1  instruction memory not ready; holds FE
- mem_wait  in  1  data memory not ready; holds MEM
- trap  in  1  exception raised by decode/execute; sampled in DE and EX only
- stage_oh  out  5  one-hot current stage, {WB,MEM,EX,DE,FE}
- stage_fire  out  5  stage_oh qualified by clk_enable and no wait; datapath latches on this
- cycle_end  out  1  high in the cycle whose rising edge ends the instruction
- retired  out  RET_W  count of instructions completed through WB
- trap_taken  out  1  one-cycle pulse, registered, after a trap abort
- wait_err  out  1  one-cycle pulse, registered, after a wait-timeout abort

Behaviour:
- **Reset:** state=FE, stage_oh=5'b00001, retired=0, trap_taken=0, wait_err=0, wait counter=0.
- **Forced-low outputs:** stage_fire and cycle_end are combinational; both are 0 whenever clk_enable=0 or rst=1.
- **States:** FE -> DE -> EX -> MEM -> WB -> FE.
- **Advance rule:** leave the current stage on a clock edge when clk_enable=1 and the stage's wait input is low.
  - fe_wait applies in FE only; mem_wait applies in MEM only.
  - Wait inputs are ignored in every other stage.
- **Idle hold:** clk_enable=0 holds all state, including the wait counter; no outputs pulse.
- **Normal cycle_end:** cycle_end = clk_enable & (WB | trap abort | timeout abort).
  - On that edge state returns to FE.
  - With the clock management unit, clk_enable drops on the following cycle, which leaves the core parked in FE.
- **Retire:** retired increments only on a WB advance.
  - Wraps modulo 2^RET_W with no flag.
- **Trap:** trap=1 with clk_enable=1 in DE or EX aborts the instruction.
  - state<=FE, cycle_end=1 that cycle, trap_taken=1 the next cycle, retired unchanged.
  - trap in FE, MEM or WB is ignored.
- **Wait counter:**
  - Increments on each edge with clk_enable=1 and the active wait held.
  - Clears on any advance, abort or stage change.
- **Wait timeout:** when the counter equals WAIT_TIMEOUT and the wait is still held with clk_enable=1, the instruction aborts.
  - state<=FE, cycle_end=1, wait_err=1 the next cycle, no retire.
- **Priority within one cycle:** rst > trap > timeout > wait hold > advance.
- **Reset mid-instruction:** returns to FE immediately; no cycle_end or pulse is generated.
- **cycle_end timing:** cycle_end depends only on registered state and same-cycle inputs, so the clock management unit's registered sampling sees it on the completing edge.

Optional Feature:
- Macro: RIVER_SEQ_PERF_EN.
- **Defined:** adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts edges with clk_enable=1.
  - perf_stalls counts edges with clk_enable=1 and an active wait held.
  - Both wrap and are cleared by rst.
- **Undefined:** these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- **Shared package river_pkg:**
  - stage encodings STG_FE..STG_WB as a 5-bit one-hot typedef.
  - STG_IDX_* bit positions.
  - STG_RESET constant.
- **Sub-module stage_wait_timer:**
  - inputs: enable, hold, clear.
  - output: expired.
  - parameters: WAIT_TIMEOUT, TO_W.
  - Instantiated once and muxed onto the active wait.
  - The RIVER_SEQ_PERF_EN counters stay inline.

Test Plan:
1. **Free run:** clk_enable=1, no waits, 10 cycles from reset.
   - Expect stage_oh FE,DE,EX,MEM,WB,FE,...
   - Expect cycle_end high on cycles 5 and 10 and retired=2.
2. **Gated hold:** clk_enable pulses high on cycles 1,4,7,9,12.
   - Expect stage advances only on those edges.
   - Expect cycle_end only with the 5th pulse, then retired=1.
3. **mem_wait hold:** mem_wait held 3 enabled cycles in MEM.
   - Expect MEM held 4 cycles total and stage_fire[3]=0 during the wait.
   - Expect WB follows and there is no wait_err.
4. **Timeout:** WAIT_TIMEOUT=4, fe_wait stuck high.
   - Expect cycle_end on the 5th enabled FE cycle.
   - Expect wait_err pulse next cycle, state FE, retired unchanged.
5. **Trap in EX:** trap=1 in EX.
   - Expect cycle_end that cycle, trap_taken next cycle, state FE, retired unchanged.
   - Expect trap asserted in MEM to have no effect.
6. **Reset mid-run:** rst asserted in MEM with mem_wait=1.
   - Expect stage_oh=00001 next cycle, retired=0, and no cycle_end, trap_taken or wait_err.

Source files
------------

// File: rtl/river_pkg.sv
// Shared stage encodings for the RIVER multicycle core.
// One-hot stage type, bit positions and reset stage.
package river_pkg;

  localparam int STG_IDX_FE  = 0;
  localparam int STG_IDX_DE  = 1;
  localparam int STG_IDX_EX  = 2;
  localparam int STG_IDX_MEM = 3;
  localparam int STG_IDX_WB  = 4;

  typedef enum logic [4:0] {
    STG_FE  = 5'b00001,
    STG_DE  = 5'b00010,
    STG_EX  = 5'b00100,
    STG_MEM = 5'b01000,
    STG_WB  = 5'b10000
  } stage_t;

  localparam stage_t STG_RESET = STG_FE;

endpackage

// File: rtl/stage_wait_timer.sv
// Wait-state timer: counts enabled cycles with hold high.
// Ports: clk, rst, enable, hold, clear in; expired out.
module stage_wait_timer #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic hold,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(WAIT_TIMEOUT);
  localparam bit TO_ON = (WAIT_TIMEOUT != 0);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && hold) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Fires on the edge after WAIT_TIMEOUT held cycles
  assign expired = TO_ON && enable && hold
                && (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_seq.sv
// RIVER stage sequencer: FE/DE/EX/MEM/WB strobes, cycle_end, retire count.
// Ports: clk_in, rst, clk_enable, fe_wait, mem_wait, trap in;
// stage_oh, stage_fire, cycle_end, retired, trap_taken, wait_err out;
// perf_cycles/perf_stalls when RIVER_SEQ_PERF_EN is defined.
module stage_seq
  import river_pkg::*;
#(
  parameter int RET_W        = 32,
  parameter int WAIT_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic             fe_wait,
  input  logic             mem_wait,
  input  logic             trap,
  output logic [4:0]       stage_oh,
  output logic [4:0]       stage_fire,
  output logic             cycle_end,
  output logic [RET_W-1:0] retired,
  output logic             trap_taken,
  output logic             wait_err
`ifdef RIVER_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  stage_t           stage_q, stage_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             trap_taken_q, trap_taken_d;
  logic             wait_err_q, wait_err_d;

  logic in_fe, in_de, in_ex, in_mem, in_wb;
  logic live, wait_act, trap_ab, to_exp, to_ab;
  logic adv, tmr_clear;

  assign in_fe  = stage_q[STG_IDX_FE];
  assign in_de  = stage_q[STG_IDX_DE];
  assign in_ex  = stage_q[STG_IDX_EX];
  assign in_mem = stage_q[STG_IDX_MEM];
  assign in_wb  = stage_q[STG_IDX_WB];

  // rst gates everything so no strobe leaks out during reset
  assign live     = clk_enable & ~rst;
  assign wait_act = (in_fe & fe_wait) | (in_mem & mem_wait);
  assign trap_ab  = live & trap & (in_de | in_ex);
  assign to_ab    = to_exp & ~trap_ab;
  assign adv      = live & ~wait_act & ~trap_ab;

  assign tmr_clear = adv | trap_ab | to_ab;

  stage_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timer (
    .clk    (clk_in),
    .rst    (rst),
    .enable (live),
    .hold   (wait_act),
    .clear  (tmr_clear),
    .expired(to_exp)
  );

  always_comb begin
    stage_d      = stage_q;
    retired_d    = retired_q;
    trap_taken_d = trap_ab;
    wait_err_d   = to_ab;
    if (trap_ab || to_ab) begin
      stage_d = STG_FE;
    end else if (adv) begin
      unique case (1'b1)
        in_fe:  stage_d = STG_DE;
        in_de:  stage_d = STG_EX;
        in_ex:  stage_d = STG_MEM;
        in_mem: stage_d = STG_WB;
        in_wb: begin
          stage_d   = STG_FE;
          retired_d = retired_q + RET_W'(1);
        end
        default: stage_d = STG_RESET;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      stage_q      <= STG_RESET;
      retired_q    <= '0;
      trap_taken_q <= 1'b0;
      wait_err_q   <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      retired_q    <= retired_d;
      trap_taken_q <= trap_taken_d;
      wait_err_q   <= wait_err_d;
    end
  end

  assign stage_oh   = stage_q;
  assign stage_fire = (live & ~wait_act) ? stage_q : 5'b0;
  assign cycle_end  = live & (in_wb | trap_ab | to_ab);
  assign retired    = retired_q;
  assign trap_taken = trap_taken_q;
  assign wait_err   = wait_err_q;

`ifdef RIVER_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q + {31'd0, live};
    perf_stalls_d = perf_stalls_q
                  + {31'd0, live & wait_act};
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_stage_seq.sv
// Self-checking bench for stage_seq with WAIT_TIMEOUT=4.
// Directed scenarios plus a randomized run against a stage-index model.
module tb_stage_seq;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en = 1'b0;
  logic fw = 1'b0;
  logic mw = 1'b0;
  logic tr = 1'b0;

  logic [4:0]  stage_oh;
  logic [4:0]  stage_fire;
  logic        cycle_end;
  logic [31:0] retired;
  logic        trap_taken;
  logic        wait_err;

  int checks = 0;
  int errors = 0;

  stage_seq #(
    .RET_W(32), .WAIT_TIMEOUT(TO), .TO_W(8)
  ) dut (
    .clk_in    (clk),
    .rst       (rst),
    .clk_enable(en),
    .fe_wait   (fw),
    .mem_wait  (mw),
    .trap      (tr),
    .stage_oh  (stage_oh),
    .stage_fire(stage_fire),
    .cycle_end (cycle_end),
    .retired   (retired),
    .trap_taken(trap_taken),
    .wait_err  (wait_err)
  );

  // Reference model: stage as index 0..4 (FE..WB)
  int          m_idx  = 0;
  int          m_wcnt = 0;
  logic [31:0] m_ret  = 0;
  logic        m_tt   = 0;
  logic        m_we   = 0;

  function automatic bit m_waiting();
    return (m_idx == 0 && fw) || (m_idx == 3 && mw);
  endfunction

  function automatic bit m_trap();
    return !rst && en && tr && (m_idx == 1 || m_idx == 2);
  endfunction

  function automatic bit m_tout();
    return !rst && en && m_waiting() && TO != 0
        && m_wcnt == TO && !m_trap();
  endfunction

  function automatic logic e_ce();
    return !rst && en && (m_idx == 4 || m_trap() || m_tout());
  endfunction

  function automatic logic [4:0] e_fire();
    if (!rst && en && !m_waiting()) return 5'(1 << m_idx);
    return 5'b0;
  endfunction

  always @(posedge clk) begin
    bit t, o, w;
    t = m_trap();
    o = m_tout();
    w = m_waiting();
    if (rst) begin
      m_idx <= 0; m_wcnt <= 0; m_ret <= 0;
      m_tt <= 0; m_we <= 0;
    end else begin
      m_tt <= t;
      m_we <= o;
      if (!en) begin
      end else if (t || o) begin
        m_idx <= 0; m_wcnt <= 0;
      end else if (w) begin
        m_wcnt <= m_wcnt + 1;
      end else begin
        if (m_idx == 4) m_ret <= m_ret + 1;
        m_idx <= (m_idx + 1) % 5;
        m_wcnt <= 0;
      end
    end
  end

  task automatic drive(input logic r, e, f, m, t);
    @(negedge clk);
    rst = r; en = e; fw = f; mw = m; tr = t;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1);
    checks++;
    if (cycle_end !== 1'b0 || stage_fire !== 5'b0) begin
      errors++;
      $display("FAIL rst_forced_low: ce=%b fire=%b want 0/00000",
               cycle_end, stage_fire);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stage_oh !== 5'b00001 || retired !== 32'd0 ||
        trap_taken !== 1'b0 || wait_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: oh=%b ret=%0d tt=%b we=%b want 00001/0/0/0",
               stage_oh, retired, trap_taken, wait_err);
    end
  endtask

  task automatic test_free_run();
    for (int c = 1; c <= 10; c++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (stage_oh !== 5'(1 << ((c - 1) % 5)) ||
          cycle_end !== (c % 5 == 0)) begin
        errors++;
        $display("FAIL free_run c%0d: oh=%b ce=%b want %b/%b", c,
                 stage_oh, cycle_end, 5'(1 << ((c - 1) % 5)),
                 (c % 5 == 0));
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (retired !== 32'd2) begin
      errors++;
      $display("FAIL free_run_retired: got %0d want 2", retired);
    end
  endtask

  task automatic test_gated_hold();
    int p;
    logic e;
    drive(1, 0, 0, 0, 0);
    p = 0;
    for (int c = 1; c <= 13; c++) begin
      e = (c == 1 || c == 4 || c == 7 || c == 9 || c == 12);
      drive(0, e, 0, 0, 0);
      checks++;
      if (stage_oh !== 5'(1 << (p % 5)) ||
          cycle_end !== (c == 12) ||
          (!e && stage_fire !== 5'b0)) begin
        errors++;
        $display("FAIL gated c%0d: oh=%b ce=%b fire=%b want %b/%b",
                 c, stage_oh, cycle_end, stage_fire,
                 5'(1 << (p % 5)), (c == 12));
      end
      if (e) p++;
    end
    checks++;
    if (retired !== 32'd1) begin
      errors++;
      $display("FAIL gated_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] r0;
    r0 = m_ret;
    repeat (3) drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, i < 3, 0);
      checks++;
      if (stage_oh !== 5'b01000 || stage_fire[3] !== (i == 3)) begin
        errors++;
        $display("FAIL mem_wait i%0d: oh=%b fire=%b want 01000/fire3=%b",
                 i, stage_oh, stage_fire, (i == 3));
      end
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (stage_oh !== 5'b10000 || cycle_end !== 1'b1 ||
        wait_err !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait_wb: oh=%b ce=%b we=%b want 10000/1/0",
               stage_oh, cycle_end, wait_err);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stage_oh !== 5'b00001 || wait_err !== 1'b0 ||
        retired !== r0 + 32'd1) begin
      errors++;
      $display("FAIL mem_wait_done: oh=%b we=%b ret=%0d want 00001/0/%0d",
               stage_oh, wait_err, retired, r0 + 32'd1);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] r0;
    r0 = m_ret;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0);
      checks++;
      if (stage_oh !== 5'b00001 || cycle_end !== (i == 4) ||
          wait_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout i%0d: oh=%b ce=%b we=%b want 00001/%b/0",
                 i, stage_oh, cycle_end, wait_err, (i == 4));
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (wait_err !== 1'b1 || stage_oh !== 5'b00001 ||
        retired !== r0) begin
      errors++;
      $display("FAIL timeout_pulse: we=%b oh=%b ret=%0d want 1/00001/%0d",
               wait_err, stage_oh, retired, r0);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (wait_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_one_shot: we=%b want 0", wait_err);
    end
  endtask

  task automatic test_trap();
    logic [31:0] r0;
    r0 = m_ret;
    repeat (2) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    checks++;
    if (stage_oh !== 5'b00100 || cycle_end !== 1'b1) begin
      errors++;
      $display("FAIL trap_ex: oh=%b ce=%b want 00100/1",
               stage_oh, cycle_end);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (trap_taken !== 1'b1 || stage_oh !== 5'b00001 ||
        retired !== r0) begin
      errors++;
      $display("FAIL trap_pulse: tt=%b oh=%b ret=%0d want 1/00001/%0d",
               trap_taken, stage_oh, retired, r0);
    end
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    checks++;
    if (stage_oh !== 5'b01000 || cycle_end !== 1'b0 ||
        stage_fire !== 5'b01000) begin
      errors++;
      $display("FAIL trap_in_mem: oh=%b ce=%b fire=%b want 01000/0/01000",
               stage_oh, cycle_end, stage_fire);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stage_oh !== 5'b10000 || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL trap_mem_ignored: oh=%b tt=%b want 10000/0",
               stage_oh, trap_taken);
    end
    drive(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    checks++;
    if (cycle_end !== 1'b0 || stage_fire !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ce=%b fire=%b want 0/00000",
               cycle_end, stage_fire);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stage_oh !== 5'b00001 || retired !== 32'd0 ||
        trap_taken !== 1'b0 || wait_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: oh=%b ret=%0d tt=%b we=%b want 00001/0/0/0",
               stage_oh, retired, trap_taken, wait_err);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 79) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0);
      checks++;
      if (stage_oh !== 5'(1 << m_idx) || stage_fire !== e_fire() ||
          cycle_end !== e_ce() || retired !== m_ret ||
          trap_taken !== m_tt || wait_err !== m_we) begin
        errors++;
        $display("FAIL random c%0d: oh=%b fire=%b ce=%b ret=%0d tt=%b we=%b want %b/%b/%b/%0d/%b/%b",
                 c, stage_oh, stage_fire, cycle_end, retired,
                 trap_taken, wait_err, 5'(1 << m_idx), e_fire(),
                 e_ce(), m_ret, m_tt, m_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_gated_hold();
    test_mem_wait();
    test_timeout();
    test_trap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
